// File: rtl/instr_encoder.sv
// RV32I field-bundle encoder feeding a 4-entry FIFO; each word is tagged with a running byte address.
// Optional build macro INSTR_ENC_RANGE_CHECK_EN rejects bundles whose immediate does not fit the format.
module instr_encoder (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  immsrc,
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [31:0] imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_addr,
    input  logic        addr_clr,
    output logic [2:0]  count,
    output logic        err
);
    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_J = 3'd3;
    localparam logic [2:0] IMM_U = 3'd4;

    logic [31:0] enc_word;
    logic        reject;
    logic        accept;
    logic        push;
    logic        pop;

    logic [31:0] instr_mem_q [4];
    logic [31:0] instr_mem_d [4];
    logic [31:0] addr_mem_q  [4];
    logic [31:0] addr_mem_d  [4];
    logic [1:0]  wr_ptr_q, wr_ptr_d;
    logic [1:0]  rd_ptr_q, rd_ptr_d;
    logic [2:0]  count_q, count_d;
    logic [31:0] addr_cnt_q, addr_cnt_d;
    logic        err_q, err_d;

    always_comb begin
        enc_word = {funct7, rs2, rs1, funct3, rd, opcode};
        case (immsrc)
            IMM_I:   enc_word = {imm[11:0], rs1, funct3, rd, opcode};
            IMM_S:   enc_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            IMM_B:   enc_word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
            IMM_J:   enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
            IMM_U:   enc_word = {imm[31:12], rd, opcode};
            default: enc_word = {funct7, rs2, rs1, funct3, rd, opcode};
        endcase
    end

`ifdef INSTR_ENC_RANGE_CHECK_EN
    // An immediate fits an N-bit signed field when every bit above the field's sign bit matches it.
    always_comb begin
        reject = 1'b0;
        case (immsrc)
            IMM_I, IMM_S: reject = !((&imm[31:11]) || !(|imm[31:11]));
            IMM_B:        reject = !((&imm[31:12]) || !(|imm[31:12])) || imm[0];
            IMM_J:        reject = !((&imm[31:20]) || !(|imm[31:20])) || imm[0];
            IMM_U:        reject = |imm[11:0];
            default:      reject = 1'b0;
        endcase
    end
`else
    assign reject = 1'b0;
`endif

    assign in_ready  = (count_q != 3'd4);
    assign out_valid = (count_q != 3'd0);
    assign accept    = in_valid && in_ready;
    assign push      = accept && !reject;
    assign pop       = out_valid && out_ready;

    always_comb begin
        instr_mem_d = instr_mem_q;
        addr_mem_d  = addr_mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        addr_cnt_d  = addr_cnt_q;
        err_d       = accept && reject;

        if (push) begin
            instr_mem_d[wr_ptr_q] = enc_word;
            addr_mem_d[wr_ptr_q]  = addr_cnt_q;
            wr_ptr_d              = wr_ptr_q + 2'd1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 2'd1;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 3'd1;
            2'b01:   count_d = count_q - 3'd1;
            default: count_d = count_q;
        endcase

        // A clear coinciding with a push lets the pushed word keep the old address,
        // so the counter lands on the address just past a zero-based word.
        if (push) begin
            addr_cnt_d = addr_clr ? 32'd4 : addr_cnt_q + 32'd4;
        end else if (addr_clr) begin
            addr_cnt_d = 32'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_mem_q <= '{default: 32'd0};
            addr_mem_q  <= '{default: 32'd0};
            wr_ptr_q    <= 2'd0;
            rd_ptr_q    <= 2'd0;
            count_q     <= 3'd0;
            addr_cnt_q  <= 32'd0;
            err_q       <= 1'b0;
        end else begin
            instr_mem_q <= instr_mem_d;
            addr_mem_q  <= addr_mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            addr_cnt_q  <= addr_cnt_d;
            err_q       <= err_d;
        end
    end

    assign out_instr = instr_mem_q[rd_ptr_q];
    assign out_addr  = addr_mem_q[rd_ptr_q];
    assign count     = count_q;
    assign err       = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: negedge scoreboard monitor plus per-scenario directed tasks.
module tb_instr_encoder;
    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_J = 3'd3;
    localparam logic [2:0] IMM_U = 3'd4;
    localparam logic [2:0] IMM_R = 3'd7;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  immsrc = 3'd0;
    logic [6:0]  opcode = 7'd0;
    logic [4:0]  rd = 5'd0;
    logic [4:0]  rs1 = 5'd0;
    logic [4:0]  rs2 = 5'd0;
    logic [2:0]  funct3 = 3'd0;
    logic [6:0]  funct7 = 7'd0;
    logic [31:0] imm = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [31:0] out_addr;
    logic        addr_clr = 1'b0;
    logic [2:0]  count;
    logic        err;

    int n_tests = 0;
    int n_fail  = 0;
    bit rand_rdy = 1'b0;

    logic [31:0] exp_instr_q[$];
    logic [31:0] exp_addr_q[$];
    logic [31:0] maddr = 32'd0;
    bit          err_exp = 1'b0;

`ifdef INSTR_ENC_RANGE_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    instr_encoder dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .immsrc(immsrc), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
        .funct3(funct3), .funct7(funct7), .imm(imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_addr(out_addr), .addr_clr(addr_clr), .count(count), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model_enc(input logic [2:0] s, input logic [6:0] op,
                                              input logic [4:0] d, input logic [4:0] r1,
                                              input logic [4:0] r2, input logic [2:0] f3,
                                              input logic [6:0] f7, input logic [31:0] im);
        logic [31:0] base;
        logic [31:0] regs;
        base = 32'(op) | (32'(f3) << 12);
        regs = (32'(r1) << 15) | (32'(r2) << 20);
        case (s)
            IMM_I:   return (im << 20) | (32'(r1) << 15) | base | (32'(d) << 7);
            IMM_S:   return (((im >> 5) & 32'h7F) << 25) | regs | base | ((im & 32'h1F) << 7);
            IMM_B:   return (((im >> 12) & 32'h1) << 31) | (((im >> 5) & 32'h3F) << 25) | regs | base
                            | (((im >> 1) & 32'hF) << 8) | (((im >> 11) & 32'h1) << 7);
            IMM_J:   return (((im >> 20) & 32'h1) << 31) | (((im >> 1) & 32'h3FF) << 21)
                            | (((im >> 11) & 32'h1) << 20) | (((im >> 12) & 32'hFF) << 12)
                            | (32'(d) << 7) | 32'(op);
            IMM_U:   return (im & 32'hFFFFF000) | (32'(d) << 7) | 32'(op);
            default: return (32'(f7) << 25) | regs | base | (32'(d) << 7);
        endcase
    endfunction

    function automatic bit model_reject(input logic [2:0] s, input logic [31:0] im);
        int v;
        v = $signed(im);
        if (!CHECK_EN) return 1'b0;
        case (s)
            IMM_I, IMM_S: return (v < -2048) || (v > 2047);
            IMM_B:        return (v < -4096) || (v > 4094) || im[0];
            IMM_J:        return (v < -1048576) || (v > 1048574) || im[0];
            IMM_U:        return im[11:0] != 12'd0;
            default:      return 1'b0;
        endcase
    endfunction

    // Scoreboard monitor: checks observable state, then predicts the coming edge.
    always @(negedge clk) begin
        if (rst) begin
            exp_instr_q.delete();
            exp_addr_q.delete();
            maddr   = 32'd0;
            err_exp = 1'b0;
        end else begin
            bit acc, pop, rej;
            n_tests++;
            if (count !== 3'(exp_instr_q.size())) begin
                n_fail++;
                $display("FAIL mon_count: got %0d expected %0d", count, exp_instr_q.size());
            end
            n_tests++;
            if (in_ready !== (exp_instr_q.size() != 4)) begin
                n_fail++;
                $display("FAIL mon_in_ready: got %b expected %b", in_ready, exp_instr_q.size() != 4);
            end
            n_tests++;
            if (out_valid !== (exp_instr_q.size() != 0)) begin
                n_fail++;
                $display("FAIL mon_out_valid: got %b expected %b", out_valid, exp_instr_q.size() != 0);
            end
            n_tests++;
            if (err !== err_exp) begin
                n_fail++;
                $display("FAIL mon_err: got %b expected %b", err, err_exp);
            end
            if (exp_instr_q.size() != 0) begin
                n_tests++;
                if (out_instr !== exp_instr_q[0] || out_addr !== exp_addr_q[0]) begin
                    n_fail++;
                    $display("FAIL mon_word: got %h@%h expected %h@%h",
                             out_instr, out_addr, exp_instr_q[0], exp_addr_q[0]);
                end
            end
            acc = in_valid && (exp_instr_q.size() != 4);
            pop = (exp_instr_q.size() != 0) && out_ready;
            rej = acc && model_reject(immsrc, imm);
            err_exp = rej;
            if (pop) begin
                void'(exp_instr_q.pop_front());
                void'(exp_addr_q.pop_front());
            end
            if (acc && !rej) begin
                exp_instr_q.push_back(model_enc(immsrc, opcode, rd, rs1, rs2, funct3, funct7, imm));
                exp_addr_q.push_back(maddr);
                maddr = addr_clr ? 32'd4 : maddr + 32'd4;
            end else if (addr_clr) begin
                maddr = 32'd0;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    end

    // Presents a bundle (called at posedge+1) and returns at posedge+1 after it is taken.
    task automatic send(input logic [2:0] s, input logic [6:0] op, input logic [4:0] d,
                        input logic [4:0] r1, input logic [4:0] r2, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] im, output int waited);
        immsrc = s; opcode = op; rd = d; rs1 = r1; rs2 = r2;
        funct3 = f3; funct7 = f7; imm = im; in_valid = 1'b1;
        waited = 0;
        @(negedge clk);
        while (!in_ready && waited < 50) begin
            waited++;
            @(negedge clk);
        end
        if (!in_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: in_ready=%b expected 1 within 50 cycles", in_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int cyc = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (out_valid && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_timeout: out_valid=%b expected 0", out_valid);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        n_tests++;
        if (count !== 3'd0 || in_ready !== 1'b1 || out_valid !== 1'b0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: count=%0d in_ready=%b out_valid=%b err=%b expected 0/1/0/0",
                     count, in_ready, out_valid, err);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_single();
        int w;
        send(IMM_I, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, w);
        in_valid = 1'b0;
        n_tests++;
        if (w != 0) begin
            n_fail++;
            $display("FAIL first_accept: waited %0d cycles expected 0", w);
        end
        n_tests++;
        if (out_valid !== 1'b1 || out_instr !== 32'h00500093 || out_addr !== 32'd0) begin
            n_fail++;
            $display("FAIL single_i: got v=%b %h@%h expected 1 00500093@0", out_valid, out_instr, out_addr);
        end
        @(posedge clk);
        #1;
        n_tests++;
        if (out_instr !== 32'h00500093 || count !== 3'd1) begin
            n_fail++;
            $display("FAIL single_hold: got %h count=%0d expected 00500093 count=1", out_instr, count);
        end
        drain();
    endtask

    task automatic test_formats();
        int w;
        addr_clr = 1'b1;
        @(posedge clk);
        #1 addr_clr = 1'b0;
        send(IMM_S, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8, w);
        send(IMM_J, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8, w);
        in_valid = 1'b0;
        n_tests++;
        if (out_instr !== 32'h0020A423 || out_addr !== 32'd0 || count !== 3'd2) begin
            n_fail++;
            $display("FAIL fmt_s: got %h@%h count=%0d expected 0020a423@0 count=2", out_instr, out_addr, count);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        n_tests++;
        if (out_instr !== 32'h008000EF || out_addr !== 32'd4) begin
            n_fail++;
            $display("FAIL fmt_j: got %h@%h expected 008000ef@4", out_instr, out_addr);
        end
        drain();
    endtask

    task automatic test_random();
        int w;
        rand_rdy = 1'b1;
        for (int i = 0; i < 24; i++) begin
            logic [31:0] r;
            logic [31:0] im;
            logic [2:0]  s;
            r = $urandom;
            s = 3'($urandom_range(0, 7));
            case (s)
                IMM_I, IMM_S: im = {{20{r[11]}}, r[11:0]};
                IMM_B:        im = {{19{r[12]}}, r[12:1], 1'b0};
                IMM_J:        im = {{11{r[20]}}, r[20:1], 1'b0};
                IMM_U:        im = {r[31:12], 12'd0};
                default:      im = r;
            endcase
            send(s, 7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                 3'($urandom), 7'($urandom), im, w);
        end
        in_valid = 1'b0;
        @(negedge clk);
        rand_rdy = 1'b0;
        @(posedge clk);
        #1;
        drain();
    endtask

    task automatic test_back_to_back();
        int w;
        addr_clr = 1'b1;
        @(posedge clk);
        #1 addr_clr = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send(IMM_I, 7'h13, 5'(i + 1), 5'd2, 5'd0, 3'd0, 7'd0, 32'(i * 16), w);
        end
        immsrc = IMM_R; opcode = 7'h33; rd = 5'd9; rs1 = 5'd3; rs2 = 5'd4;
        funct3 = 3'd0; funct7 = 7'h20; imm = 32'd0; in_valid = 1'b1;
        n_tests++;
        if (count !== 3'd4 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL full_stall: count=%0d in_ready=%b expected 4/0", count, in_ready);
        end
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (count !== 3'd4 || out_addr !== 32'd0) begin
            n_fail++;
            $display("FAIL full_hold: count=%0d addr=%h expected 4/0", count, out_addr);
        end
        out_ready = 1'b1;
        send(IMM_R, 7'h33, 5'd9, 5'd3, 5'd4, 3'd0, 7'h20, 32'd0, w);
        in_valid = 1'b0;
        drain();
        send(IMM_U, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, w);
        in_valid = 1'b0;
        n_tests++;
        if (out_addr !== 32'd20 || out_instr !== 32'h123452B7) begin
            n_fail++;
            $display("FAIL after_five: got %h@%h expected 123452b7@14", out_instr, out_addr);
        end
        drain();
    endtask

    task automatic test_addr_clr();
        int w;
        addr_clr = 1'b1;
        send(IMM_I, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1, w);
        addr_clr = 1'b0;
        send(IMM_I, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2, w);
        in_valid = 1'b0;
        n_tests++;
        if (out_addr !== 32'd24 || count !== 3'd2) begin
            n_fail++;
            $display("FAIL clr_coincident_tag: addr=%h count=%0d expected 18/2", out_addr, count);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        n_tests++;
        if (out_addr !== 32'd4) begin
            n_fail++;
            $display("FAIL clr_coincident_next: addr=%h expected 4", out_addr);
        end
        drain();
        addr_clr = 1'b1;
        @(posedge clk);
        #1 addr_clr = 1'b0;
        send(IMM_I, 7'h13, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3, w);
        in_valid = 1'b0;
        n_tests++;
        if (out_addr !== 32'd0) begin
            n_fail++;
            $display("FAIL clr_alone: addr=%h expected 0", out_addr);
        end
        drain();
    endtask

    task automatic test_range();
        int w;
        logic [2:0]  rs[8];
        logic [31:0] ri[8];
        logic [2:0]  as[8];
        logic [31:0] ai[8];
        send(IMM_I, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, w);
        in_valid = 1'b0;
        if (CHECK_EN) begin
            n_tests++;
            if (err !== 1'b1 || count !== 3'd0) begin
                n_fail++;
                $display("FAIL reject_2048: err=%b count=%0d expected 1/0", err, count);
            end
            @(posedge clk);
            #1;
            n_tests++;
            if (err !== 1'b0) begin
                n_fail++;
                $display("FAIL reject_pulse: err=%b expected 0", err);
            end
            send(IMM_I, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, w);
            in_valid = 1'b0;
            n_tests++;
            if (out_addr !== 32'd4) begin
                n_fail++;
                $display("FAIL reject_addr: addr=%h expected 4", out_addr);
            end
        end else begin
            n_tests++;
            if (out_instr !== 32'h80000093 || err !== 1'b0 || count !== 3'd1) begin
                n_fail++;
                $display("FAIL trunc_2048: got %h err=%b count=%0d expected 80000093/0/1",
                         out_instr, err, count);
            end
        end
        drain();
        rs = '{IMM_I, IMM_S, IMM_B, IMM_B, IMM_J, IMM_J, IMM_U, IMM_B};
        ri = '{32'd2048, 32'hFFFFF7FF, 32'd3, 32'd4096, 32'd1048576, 32'd5, 32'h00001001, 32'hFFFFEFFE};
        as = '{IMM_I, IMM_I, IMM_S, IMM_B, IMM_B, IMM_J, IMM_J, IMM_U};
        ai = '{32'hFFFFF800, 32'd2047, 32'hFFFFF800, 32'd4094, 32'hFFFFF000, 32'd1048574,
               32'hFFF00000, 32'hFFFFF000};
        for (int i = 0; i < 8; i++) begin
            send(rs[i], 7'h63, 5'd7, 5'd8, 5'd9, 3'd1, 7'd0, ri[i], w);
            in_valid = 1'b0;
            n_tests++;
            if (err !== CHECK_EN || count !== 3'(!CHECK_EN)) begin
                n_fail++;
                $display("FAIL reject_tbl[%0d]: err=%b count=%0d expected %b/%0d",
                         i, err, count, CHECK_EN, !CHECK_EN);
            end
            drain();
        end
        for (int i = 0; i < 8; i++) begin
            send(as[i], 7'h67, 5'd3, 5'd4, 5'd5, 3'd0, 7'd0, ai[i], w);
            in_valid = 1'b0;
            n_tests++;
            if (err !== 1'b0 || count !== 3'd1) begin
                n_fail++;
                $display("FAIL accept_tbl[%0d]: err=%b count=%0d expected 0/1", i, err, count);
            end
            drain();
        end
    endtask

    task automatic test_reset_mid();
        int w;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send(IMM_R, 7'h33, 5'(i), 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, w);
        end
        in_valid = 1'b0;
        n_tests++;
        if (count !== 3'd3) begin
            n_fail++;
            $display("FAIL pre_reset_count: got %0d expected 3", count);
        end
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || count !== 3'd0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL async_reset: out_valid=%b count=%0d in_ready=%b expected 0/0/1",
                     out_valid, count, in_ready);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        send(IMM_I, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, w);
        in_valid = 1'b0;
        n_tests++;
        if (w != 0 || out_addr !== 32'd0 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL post_reset: waited=%0d addr=%h v=%b expected 0/0/1", w, out_addr, out_valid);
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_single();
        test_formats();
        test_random();
        test_back_to_back();
        test_addr_clr();
        test_range();
        test_reset_mid();
        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
